id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I pipeline.
- Captures the decode-stage control bundle (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch), operands and register fields for the execute stage.
- Contains the load-use hazard detector: drives a one-cycle stall to PC/IF-ID and inserts a bubble.
- Honours a branch flush from EX/MEM.

Parameters:
- PC_W, 9, width of the PC field.
- DATA_W, 32, width of register-file operands and the immediate.
- CNT_W, 32, width of the performance counters (used only with ID_EX_PERF_CNT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_pc  in  PC_W  PC of the ID instruction.
- id_rd1, id_rd2  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5  register indices.
- id_funct3  in  3  funct3 field.
- id_funct7  in  7  funct7 field.
- ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  in  1  controller outputs.
- ALUOp  in  2  controller ALUOp (00 LW/SW, 01 branch, 10 R/I-type).
- flush  in  1  branch taken in EX/MEM; kill the ID instruction.
- ex_valid  out  1  registered valid.
- ex_pc  out  PC_W  registered PC.
- ex_rd1, ex_rd2, ex_imm  out  DATA_W  registered data.
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices.
- ex_funct3  out  3  registered funct3.
- ex_funct7  out  7  registered funct7.
- ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch  out  1  registered control.
- ex_ALUOp  out  2  registered ALUOp.
- hazard_stall  out  1  combinational; PC and IF/ID hold their value this cycle.

Behaviour:
- Reset: all ex_* outputs are 0 on the first clock edge with reset=1. hazard_stall is 0 while reset=1. Reset mid-stall: the stall ends at that edge and no instruction is captured.
- uses_rs2 = (ALUSrc==0) | MemWrite, i.e. R-type, beq and sw.
- load_use = ex_valid & ex_MemRead & (ex_rd!=0) & id_valid & ((id_rs1==ex_rd) | (uses_rs2 & (id_rs2==ex_rd))).
- hazard_stall = load_use & ~flush & ~reset. This is purely combinational, with no added latency.
- Per-edge priority:
  1. reset → all zero.
  2. flush → bubble.
  3. load_use → bubble.
  4. id_valid=0 → bubble.
  5. Otherwise capture all id_* and control inputs; ex_valid=1.
- Bubble: ex_valid and all seven control outputs (ALUOp = 00) are 0. Data, index, funct and PC fields keep their previous values and carry no meaning.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- A stall always lasts exactly one cycle. The bubble sets ex_valid=0, which clears load_use on the next cycle, so the held instruction is captured then.
- Simultaneous flush and load_use: flush wins, hazard_stall=0, bubble inserted.
- ex_rd==0 with ex_MemRead=1 (lw x0) never stalls.
- ex_valid=0 never stalls, even when the stale ex_MemRead/ex_rd values would match.
- Control outputs are never X after reset.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: adds outputs stall_cnt and flush_cnt, each CNT_W wide.
  - Both are 0 on reset.
  - stall_cnt increments on each edge where hazard_stall=1.
  - flush_cnt increments on each edge where flush=1 and reset=0.
  - Both saturate at all-ones (no wrap).
- Undefined: the counters and both ports are absent; all other behaviour is identical.

Test Plan:
- Reset: drive reset=1 for 2 cycles with id_valid=1 and RegWrite=1 → all ex_* = 0 and hazard_stall = 0; after release, the next edge captures the inputs.
- Normal capture: add x3,x1,x2 (ALUOp=10, RegWrite=1, id_rd1=5, id_rd2=7, id_pc=0x10) → one edge later ex_valid=1, ex_RegWrite=1, ex_ALUOp=10, ex_rd1=5, ex_rd2=7, ex_rd=3, ex_pc=0x10.
- Load-use: lw x5 in EX (ex_MemRead=1, ex_rd=5), then add x6,x5,x1 in ID → hazard_stall=1 for exactly 1 cycle and a bubble is inserted (ex_valid=0, control 0); the next edge captures the add with ex_rs1=5.
- rs2 qualification: lw x5 in EX, then addi x6,x1,0 in ID with id_rs2=5 (ALUSrc=1) → hazard_stall=0. Same setup with sw x5,0(x1) → hazard_stall=1. lw x0 followed by a consumer of x0 → hazard_stall=0.
- Flush priority: load-use condition plus flush=1 on the same cycle → hazard_stall=0 and the next state is a bubble. Flush alone with a valid beq in ID → ex_Branch=0, ex_valid=0.
- Perf counters (ID_EX_PERF_CNT_EN): 3 load-use events and 2 flushes → stall_cnt=3, flush_cnt=2. With CNT_W=2 and 5 stalls → stall_cnt holds at 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with the load-use hazard detector for a 5-stage RV32I pipeline.
// Optional stall/flush performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int PC_W   = 9,
  parameter int DATA_W = 32
`ifdef ID_EX_PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic              ALUSrc,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Branch,
  input  logic [1:0]        ALUOp,
  input  logic              flush,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic              ex_ALUSrc,
  output logic              ex_MemtoReg,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Branch,
  output logic [1:0]        ex_ALUOp,
  output logic              hazard_stall
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
  } payload_t;

  ctrl_t    id_ctrl;
  payload_t id_payload;

  logic     valid_q,   valid_d;
  ctrl_t    ctrl_q,    ctrl_d;
  payload_t payload_q, payload_d;

  logic uses_rs2;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic bubble;

  assign id_ctrl = '{
    alu_src:    ALUSrc,
    mem_to_reg: MemtoReg,
    reg_write:  RegWrite,
    mem_read:   MemRead,
    mem_write:  MemWrite,
    branch:     Branch,
    alu_op:     ALUOp
  };

  assign id_payload = '{
    pc:     id_pc,
    rd1:    id_rd1,
    rd2:    id_rd2,
    imm:    id_imm,
    rs1:    id_rs1,
    rs2:    id_rs2,
    rd:     id_rd,
    funct3: id_funct3,
    funct7: id_funct7
  };

  // rs2 is only a real source for R-type, branches and stores; I-type/loads reuse its bits.
  assign uses_rs2 = ~ALUSrc | MemWrite;
  assign rs1_hit  = (id_rs1 == payload_q.rd);
  assign rs2_hit  = (id_rs2 == payload_q.rd);

  assign load_use = valid_q & ctrl_q.mem_read & (payload_q.rd != 5'd0) & id_valid &
                    (rs1_hit | (uses_rs2 & rs2_hit));

  // A flush kills the consumer anyway, so holding PC/IF-ID for it would waste a cycle.
  assign hazard_stall = load_use & ~flush & ~reset;

  assign bubble = flush | load_use | ~id_valid;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    valid_d   = 1'b0;
    ctrl_d    = '0;
    payload_d = payload_q;
    if (!bubble) begin
      valid_d   = 1'b1;
      ctrl_d    = id_ctrl;
      payload_d = id_payload;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      payload_q <= payload_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = payload_q.pc;
  assign ex_rd1      = payload_q.rd1;
  assign ex_rd2      = payload_q.rd2;
  assign ex_imm      = payload_q.imm;
  assign ex_rs1      = payload_q.rs1;
  assign ex_rs2      = payload_q.rs2;
  assign ex_rd       = payload_q.rd;
  assign ex_funct3   = payload_q.funct3;
  assign ex_funct7   = payload_q.funct7;
  assign ex_ALUSrc   = ctrl_q.alu_src;
  assign ex_MemtoReg = ctrl_q.mem_to_reg;
  assign ex_RegWrite = ctrl_q.reg_write;
  assign ex_MemRead  = ctrl_q.mem_read;
  assign ex_MemWrite = ctrl_q.mem_write;
  assign ex_Branch   = ctrl_q.branch;
  assign ex_ALUOp    = ctrl_q.alu_op;

`ifdef ID_EX_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Counters saturate at all-ones so a long run never reports a small wrapped value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/flush/reset scenarios followed by
// randomized traffic checked against a transaction-level model of the ID/EX register.
module tb_id_ex_stage;

  localparam int PC_W   = 9;
  localparam int DATA_W = 32;
`ifdef ID_EX_PERF_CNT_EN
  localparam int CNT_W  = 32;
`endif

  typedef struct {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] rd1, rd2, imm;
    logic [4:0]        rs1, rs2, rd;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic              alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
    logic [1:0]        alu_op;
  } instr_t;

  logic clk = 1'b0;
  logic reset;
  logic id_valid;
  logic [PC_W-1:0] id_pc;
  logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_funct3;
  logic [6:0] id_funct7;
  logic ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0] ALUOp;
  logic flush;
  logic ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic [6:0] ex_funct7;
  logic ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch;
  logic [1:0] ex_ALUOp;
  logic hazard_stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [CNT_W-1:0] m_stall_cnt, m_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  instr_t m;

  always #5 clk = ~clk;

  id_ex_stage #(
    .PC_W(PC_W),
    .DATA_W(DATA_W)
`ifdef ID_EX_PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7(id_funct7),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
    .ex_ALUOp(ex_ALUOp), .hazard_stall(hazard_stall)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Instruction builders: random payload, control set from the instruction class.
  function automatic instr_t base(input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd);
    instr_t t;
    t.valid = 1'b1;
    t.pc = PC_W'($urandom);
    t.rd1 = $urandom; t.rd2 = $urandom; t.imm = $urandom;
    t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.f3 = 3'($urandom); t.f7 = 7'($urandom);
    t.alu_src = 1'b0; t.mem_to_reg = 1'b0; t.reg_write = 1'b0;
    t.mem_read = 1'b0; t.mem_write = 1'b0; t.branch = 1'b0; t.alu_op = 2'b00;
    return t;
  endfunction

  function automatic instr_t r_type(input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [4:0] rd);
    instr_t t = base(rs1, rs2, rd);
    t.reg_write = 1'b1; t.alu_op = 2'b10;
    return t;
  endfunction

  function automatic instr_t i_type(input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [4:0] rd);
    instr_t t = base(rs1, rs2, rd);
    t.alu_src = 1'b1; t.reg_write = 1'b1; t.alu_op = 2'b10;
    return t;
  endfunction

  function automatic instr_t lw(input logic [4:0] rs1, input logic [4:0] rd);
    instr_t t = base(rs1, 5'($urandom), rd);
    t.alu_src = 1'b1; t.mem_to_reg = 1'b1; t.reg_write = 1'b1; t.mem_read = 1'b1;
    return t;
  endfunction

  function automatic instr_t sw(input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t t = base(rs1, rs2, 5'($urandom));
    t.alu_src = 1'b1; t.mem_write = 1'b1;
    return t;
  endfunction

  function automatic instr_t beq(input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t t = base(rs1, rs2, 5'($urandom));
    t.branch = 1'b1; t.alu_op = 2'b01;
    return t;
  endfunction

  // Reference rule: the instruction in EX is a real load of a nonzero register that the
  // ID instruction actually reads; a flush or reset overrides the stall.
  function automatic logic model_load_use(input instr_t in);
    logic reads_rs2;
    reads_rs2 = !in.alu_src || in.mem_write;
    return m.valid && m.mem_read && (m.rd != 5'd0) && in.valid &&
           ((in.rs1 == m.rd) || (reads_rs2 && (in.rs2 == m.rd)));
  endfunction

  task automatic check_ex();
    check("ex_valid",    ex_valid,    m.valid);
    check("ex_pc",       ex_pc,       m.pc);
    check("ex_rd1",      ex_rd1,      m.rd1);
    check("ex_rd2",      ex_rd2,      m.rd2);
    check("ex_imm",      ex_imm,      m.imm);
    check("ex_rs1",      ex_rs1,      m.rs1);
    check("ex_rs2",      ex_rs2,      m.rs2);
    check("ex_rd",       ex_rd,       m.rd);
    check("ex_funct3",   ex_funct3,   m.f3);
    check("ex_funct7",   ex_funct7,   m.f7);
    check("ex_ALUSrc",   ex_ALUSrc,   m.alu_src);
    check("ex_MemtoReg", ex_MemtoReg, m.mem_to_reg);
    check("ex_RegWrite", ex_RegWrite, m.reg_write);
    check("ex_MemRead",  ex_MemRead,  m.mem_read);
    check("ex_MemWrite", ex_MemWrite, m.mem_write);
    check("ex_Branch",   ex_Branch,   m.branch);
    check("ex_ALUOp",    ex_ALUOp,    m.alu_op);
`ifdef ID_EX_PERF_CNT_EN
    check("stall_cnt",   stall_cnt,   m_stall_cnt);
    check("flush_cnt",   flush_cnt,   m_flush_cnt);
`endif
  endtask

  // One pipeline cycle: drive ID inputs, check the combinational stall, clock, check EX.
  task automatic step(input instr_t in, input logic fl, input logic rst, output logic stall_seen);
    logic lu, exp_stall;
    id_valid = in.valid; id_pc = in.pc; id_rd1 = in.rd1; id_rd2 = in.rd2; id_imm = in.imm;
    id_rs1 = in.rs1; id_rs2 = in.rs2; id_rd = in.rd; id_funct3 = in.f3; id_funct7 = in.f7;
    ALUSrc = in.alu_src; MemtoReg = in.mem_to_reg; RegWrite = in.reg_write;
    MemRead = in.mem_read; MemWrite = in.mem_write; Branch = in.branch; ALUOp = in.alu_op;
    flush = fl; reset = rst;
    #1;
    lu = model_load_use(in);
    exp_stall = lu && !fl && !rst;
    check("hazard_stall", hazard_stall, exp_stall);
    stall_seen = hazard_stall;
    @(posedge clk);
    if (rst) begin
      m = '{default: '0};
`ifdef ID_EX_PERF_CNT_EN
      m_stall_cnt = '0; m_flush_cnt = '0;
`endif
    end else begin
`ifdef ID_EX_PERF_CNT_EN
      if (exp_stall && m_stall_cnt != '1) m_stall_cnt = m_stall_cnt + 1'b1;
      if (fl && m_flush_cnt != '1) m_flush_cnt = m_flush_cnt + 1'b1;
`endif
      if (fl || lu || !in.valid) begin
        m.valid = 1'b0; m.alu_src = 1'b0; m.mem_to_reg = 1'b0; m.reg_write = 1'b0;
        m.mem_read = 1'b0; m.mem_write = 1'b0; m.branch = 1'b0; m.alu_op = 2'b00;
      end else begin
        m = in;
      end
    end
    #1;
    check_ex();
    @(negedge clk);
  endtask

  initial begin
    instr_t t;
    logic st;
    m = '{default: '0};
`ifdef ID_EX_PERF_CNT_EN
    m_stall_cnt = '0; m_flush_cnt = '0;
`endif

    // Reset held for two edges with a valid RegWrite instruction presented.
    t = r_type(5'd1, 5'd2, 5'd3);
    step(t, 1'b0, 1'b1, st);
    check("rst_stall", st, 1'b0);
    step(t, 1'b0, 1'b1, st);
    check("rst_valid", ex_valid, 1'b0);
    check("rst_regwrite", ex_RegWrite, 1'b0);

    // add x3,x1,x2 captured one edge after release.
    t = r_type(5'd1, 5'd2, 5'd3);
    t.rd1 = 32'd5; t.rd2 = 32'd7; t.pc = 9'h010;
    step(t, 1'b0, 1'b0, st);
    check("add_valid", ex_valid, 1'b1);
    check("add_aluop", ex_ALUOp, 2'b10);
    check("add_rd1", ex_rd1, 32'd5);
    check("add_rd2", ex_rd2, 32'd7);
    check("add_rd", ex_rd, 5'd3);
    check("add_pc", ex_pc, 9'h010);

    // Load-use on rs1: one stall cycle, bubble, then the held add is captured.
    step(lw(5'd1, 5'd5), 1'b0, 1'b0, st);
    t = r_type(5'd5, 5'd1, 5'd6);
    step(t, 1'b0, 1'b0, st);
    check("lu_stall", st, 1'b1);
    check("lu_bubble_valid", ex_valid, 1'b0);
    check("lu_bubble_regwrite", ex_RegWrite, 1'b0);
    step(t, 1'b0, 1'b0, st);
    check("lu_second_stall", st, 1'b0);
    check("lu_capture_rs1", ex_rs1, 5'd5);
    check("lu_capture_valid", ex_valid, 1'b1);

    // rs2 only counts when the consumer really reads it.
    step(lw(5'd1, 5'd5), 1'b0, 1'b0, st);
    step(i_type(5'd1, 5'd5, 5'd6), 1'b0, 1'b0, st);
    check("addi_rs2_nostall", st, 1'b0);
    step(lw(5'd1, 5'd5), 1'b0, 1'b0, st);
    t = sw(5'd1, 5'd5);
    step(t, 1'b0, 1'b0, st);
    check("sw_rs2_stall", st, 1'b1);
    step(t, 1'b0, 1'b0, st);
    step(lw(5'd1, 5'd0), 1'b0, 1'b0, st);
    step(r_type(5'd0, 5'd0, 5'd7), 1'b0, 1'b0, st);
    check("lw_x0_nostall", st, 1'b0);

    // Flush beats load-use; flush alone kills a valid beq.
    step(lw(5'd1, 5'd5), 1'b0, 1'b0, st);
    step(r_type(5'd5, 5'd2, 5'd6), 1'b1, 1'b0, st);
    check("flush_lu_stall", st, 1'b0);
    check("flush_lu_valid", ex_valid, 1'b0);
    step(beq(5'd1, 5'd2), 1'b1, 1'b0, st);
    check("flush_beq_branch", ex_Branch, 1'b0);
    check("flush_beq_valid", ex_valid, 1'b0);

    // Stale EX fields after a bubble must not stall.
    step(lw(5'd1, 5'd5), 1'b0, 1'b0, st);
    t = base(5'd1, 5'd2, 5'd3); t.valid = 1'b0;
    step(t, 1'b0, 1'b0, st);
    step(r_type(5'd5, 5'd5, 5'd6), 1'b0, 1'b0, st);
    check("stale_ex_nostall", st, 1'b0);

    // Reset arriving during a stall ends it and captures nothing.
    step(lw(5'd1, 5'd5), 1'b0, 1'b0, st);
    step(r_type(5'd5, 5'd1, 5'd6), 1'b0, 1'b1, st);
    check("rst_midstall_stall", st, 1'b0);
    check("rst_midstall_valid", ex_valid, 1'b0);

    // Randomized traffic on a small register window so hazards occur often.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] a, b, d;
      a = 5'($urandom_range(0, 4)); b = 5'($urandom_range(0, 4)); d = 5'($urandom_range(0, 4));
      case ($urandom_range(0, 4))
        0: t = r_type(a, b, d);
        1: t = i_type(a, b, d);
        2: t = lw(a, d);
        3: t = sw(a, b);
        default: t = beq(a, b);
      endcase
      t.valid = ($urandom_range(0, 7) != 0);
      step(t, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0), st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
